uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (legal 5..13).
REQ-002 The block SHALL have port clk, input, 1, the single clock.
REQ-003 The block SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port rx_in, input, 1, the serial line (idle high).
REQ-005 The block SHALL have port sampled_bit, input, 1, the majority-voted bit value from the data sampler.
REQ-006 The block SHALL have port prescale, input, 5, edges per bit (legal 4..31), stable for a whole frame.
REQ-007 The block SHALL have port par_en, input, 1, parity bit present when 1.
REQ-008 The block SHALL have port par_typ, input, 1, 0 = even and 1 = odd parity.
REQ-009 The block SHALL have port bit_cnt, input, 4, from edge_bit_counter.
REQ-010 The block SHALL have port edge_cnt, input, 5, from edge_bit_counter.
REQ-011 The block SHALL have port en_counter, output, 1, which drives the en_counter input of edge_bit_counter.
REQ-012 The block SHALL have port cnt_clr, output, 1, which drives the data_valid (clear) input of edge_bit_counter.
REQ-013 The block SHALL have port data_samp_en, output, 1, the sampler enable.
REQ-014 The block SHALL have ports p_data (output, DATA_WIDTH, received word), data_valid (output, 1), par_err (output, 1) and stp_err (output, 1).
REQ-015 The block SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-016 The block SHALL implement a registered FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-017 A "last edge" SHALL mean en_counter=1 and edge_cnt==prescale-1, with the comparison done at 5-bit width.
REQ-018 In the IDLE state, rx_in=0 SHALL cause a transition to START on the next clock.
REQ-019 In the START state, at the last edge: sampled_bit=0 -> DATA; sampled_bit=1 (glitch) -> IDLE, with no data_valid, par_err or stp_err.
REQ-020 In the DATA state, each last edge SHALL shift sampled_bit into the shift register LSB-first (new bit enters at the MSB, shift right).
REQ-021 In the DATA state, at the last edge with bit_cnt==DATA_WIDTH, the next state SHALL be PARITY if par_en=1, otherwise STOP.
REQ-022 In the PARITY state, at the last edge, the block SHALL latch an internal parity error when sampled_bit != (^shreg XOR par_typ), then go to STOP.
REQ-023 In the STOP state, at the last edge, the block SHALL go to IDLE and evaluate the stop bit: stop error = (sampled_bit==0).
REQ-024 One clock after the STOP last edge, data_valid SHALL pulse high for exactly 1 cycle if there is no parity error and no stop error, with p_data <= shreg in the same cycle.
REQ-025 In the same cycle as REQ-024, par_err and stp_err SHALL pulse for 1 cycle as applicable; both may pulse together, and data_valid SHALL then stay 0.
REQ-026 p_data SHALL update only on a valid frame and SHALL hold its value otherwise.
REQ-027 en_counter, data_samp_en and busy SHALL equal (state != IDLE), decoded from the registered state.
REQ-028 cnt_clr SHALL pulse high for exactly 1 cycle, registered, on every entry to IDLE from START or STOP, so the counters are zero before the next frame.
REQ-029 If rx_in=0 during the cnt_clr cycle, the block SHALL enter START on the next clock; back-to-back frames SHALL be supported with no idle gap.
REQ-030 The internal parity-error flag SHALL be cleared on entry to START.
REQ-031 Changes to prescale, par_en or par_typ mid-frame SHALL have undefined results and are not checked.

Reset
REQ-032 When rst=0 at a clk edge, the state SHALL become IDLE; shreg, p_data, data_valid, par_err, stp_err, cnt_clr and the internal parity flag SHALL become 0; en_counter, data_samp_en and busy SHALL become 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no output pulse; the counter is reset by the same rst.
REQ-034 After reset release, the first falling rx_in SHALL start a frame normally.

Verification
REQ-035 Scenario (no parity, good frame): prescale=8, par_en=0, byte 0xA5 LSB-first plus stop=1 -> data_valid=1 for 1 cycle, 1 clock after the STOP last edge, with p_data=0xA5 and par_err=stp_err=0.
REQ-036 Scenario (even parity): prescale=16, par_en=1, par_typ=0, byte 0x3C, parity bit 0 -> p_data=0x3C and data_valid pulse; repeating with parity bit 1 -> par_err pulse, data_valid=0, p_data still 0x3C.
REQ-037 Scenario (odd parity): par_typ=1, byte 0x01, parity bit 0 -> data_valid pulse and p_data=0x01.
REQ-038 Scenario (stop error): byte 0x55 with stop bit=0 -> stp_err pulse, data_valid=0, cnt_clr pulse, then IDLE.
REQ-039 Scenario (start glitch): rx_in low 2 cycles, sampled_bit=1 at the START last edge -> return to IDLE, cnt_clr pulse, no data_valid, par_err or stp_err, and bit_cnt=edge_cnt=0 on the following cycle.
REQ-040 Scenario (reset mid-frame and back-to-back): rst=0 in DATA at bit 4 -> all outputs 0 on the next clock and the next frame decodes correctly; two frames 0x12 then 0x34 with no gap -> two data_valid pulses in order.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM that steers an external edge/bit counter and
// data sampler, assembles the word LSB-first and reports parity/stop errors.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  sampled_bit,
    input  logic [4:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [3:0]            bit_cnt,
    input  logic [4:0]            edge_cnt,
    output logic                  en_counter,
    output logic                  cnt_clr,
    output logic                  data_samp_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  cnt_clr_q, cnt_clr_d;
    logic                  par_flag_q, par_flag_d;
    logic                  active;
    logic                  last_edge;

    assign active    = (state_q != IDLE);
    assign last_edge = active && (edge_cnt == (prescale - 5'd1));

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        p_data_d     = p_data_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        cnt_clr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d    = START;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    if (sampled_bit) begin
                        state_d   = IDLE;
                        cnt_clr_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_edge) begin
                    shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state_d = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    par_flag_d = (sampled_bit != ((^shreg_q) ^ par_typ));
                    state_d    = STOP;
                end
            end
            STOP: begin
                // Result flags are registered here so they appear the cycle after the stop sample.
                if (last_edge) begin
                    state_d   = IDLE;
                    cnt_clr_d = 1'b1;
                    stp_err_d = ~sampled_bit;
                    par_err_d = par_flag_q;
                    if (!par_flag_q && sampled_bit) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shreg_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            cnt_clr_q    <= 1'b0;
            par_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            cnt_clr_q    <= cnt_clr_d;
            par_flag_q   <= par_flag_d;
        end
    end

    assign en_counter   = active;
    assign data_samp_en = active;
    assign busy         = active;
    assign cnt_clr      = cnt_clr_q;
    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign par_err      = par_err_q;
    assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl; includes a behavioural edge/bit counter
// so the controller sees realistic bit_cnt/edge_cnt sequences.
module tb_uart_rx_ctrl;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          sampled_bit;
    logic [4:0]    prescale;
    logic          par_en;
    logic          par_typ;
    logic [3:0]    bit_cnt;
    logic [4:0]    edge_cnt;
    logic          en_counter;
    logic          cnt_clr;
    logic          data_samp_en;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    typedef struct packed {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .sampled_bit  (sampled_bit),
        .prescale     (prescale),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .bit_cnt      (bit_cnt),
        .edge_cnt     (edge_cnt),
        .en_counter   (en_counter),
        .cnt_clr      (cnt_clr),
        .data_samp_en (data_samp_en),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .busy         (busy)
    );

    // Edge/bit counter: cleared by rst or cnt_clr, counts edges while enabled.
    always @(posedge clk) begin
        if (!rst || cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en_counter) begin
            if (edge_cnt == prescale - 5'd1) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic sb_expect(input logic dv, input logic pe, input logic se, input logic [DW-1:0] d);
        exp_t e;
        e.dv   = dv;
        e.pe   = pe;
        e.se   = se;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Bit 0 is the start bit, then data LSB-first, optional parity, stop.
    function automatic logic [15:0] frame(input logic [7:0] d, input logic pen,
                                           input logic pbit, input logic stop);
        logic [15:0] b;
        b      = '0;
        b[8:1] = d;
        if (pen) begin
            b[9]  = pbit;
            b[10] = stop;
        end else begin
            b[9] = stop;
        end
        return b;
    endfunction

    // Returns just after the clock edge that consumed the last listed bit.
    task automatic send_bits(input logic [15:0] bits, input int n);
        int   t;
        logic hit;
        rx_in = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < n; k++) begin
            sampled_bit = bits[k];
            t = 0;
            do begin
                @(negedge clk);
                rx_in = bits[k];
                t++;
                hit = en_counter && (edge_cnt == prescale - 5'd1);
            end while (!hit && t < 64);
            if (!hit) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bit_timeout: bit %0d got no last edge in %0d cycles, expected one", k, t);
                rx_in = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got dv=%0b pe=%0b se=%0b p_data=%0h, expected no pulse",
                         data_valid, par_err, stp_err, p_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_data_valid", 32'(data_valid), 32'(mon_e.dv));
                check("mon_par_err",    32'(par_err),    32'(mon_e.pe));
                check("mon_stp_err",    32'(stp_err),    32'(mon_e.se));
                check("mon_p_data",     32'(p_data),     32'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        rx_in       = 1'b1;
        sampled_bit = 1'b1;
        prescale    = 5'd8;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",       32'(busy),         0);
        check("rst_en_counter", 32'(en_counter),   0);
        check("rst_samp_en",    32'(data_samp_en), 0);
        check("rst_cnt_clr",    32'(cnt_clr),      0);
        check("rst_data_valid", 32'(data_valid),   0);
        check("rst_par_err",    32'(par_err),      0);
        check("rst_stp_err",    32'(stp_err),      0);
        check("rst_p_data",     32'(p_data),       0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_stays_idle", 32'(busy), 0);

        // No parity, 0xA5
        sb_expect(1'b1, 1'b0, 1'b0, 8'hA5);
        send_bits(frame(8'hA5, 1'b0, 1'b0, 1'b1), 10);
        check("a5_dv_timing", 32'(data_valid), 1);
        check("a5_cnt_clr",   32'(cnt_clr),    1);
        check("a5_busy_done", 32'(busy),       0);
        @(posedge clk);
        #1;
        check("a5_dv_width",      32'(data_valid), 0);
        check("a5_cnt_clr_width", 32'(cnt_clr),    0);
        repeat (3) @(posedge clk);
        #1;

        // Even parity, good then bad parity bit
        prescale = 5'd16;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        sb_expect(1'b1, 1'b0, 1'b0, 8'h3C);
        send_bits(frame(8'h3C, 1'b1, 1'b0, 1'b1), 11);
        repeat (3) @(posedge clk);
        #1;
        sb_expect(1'b0, 1'b1, 1'b0, 8'h3C);
        send_bits(frame(8'h3C, 1'b1, 1'b1, 1'b1), 11);
        check("pe_no_dv", 32'(data_valid), 0);
        repeat (3) @(posedge clk);
        #1;

        // Odd parity
        par_typ = 1'b1;
        sb_expect(1'b1, 1'b0, 1'b0, 8'h01);
        send_bits(frame(8'h01, 1'b1, 1'b0, 1'b1), 11);
        repeat (3) @(posedge clk);
        #1;

        // Stop error
        par_en   = 1'b0;
        prescale = 5'd8;
        sb_expect(1'b0, 1'b0, 1'b1, 8'h01);
        send_bits(frame(8'h55, 1'b0, 1'b0, 1'b0), 10);
        check("se_cnt_clr", 32'(cnt_clr), 1);
        check("se_busy",    32'(busy),    0);
        @(posedge clk);
        #1;
        check("se_idle", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1;

        // Start glitch
        send_bits(16'h0001, 1);
        check("gl_cnt_clr", 32'(cnt_clr),    1);
        check("gl_busy",    32'(busy),       0);
        check("gl_dv",      32'(data_valid), 0);
        check("gl_pe",      32'(par_err),    0);
        check("gl_se",      32'(stp_err),    0);
        @(posedge clk);
        #1;
        check("gl_bit_cnt",  32'(bit_cnt),  0);
        check("gl_edge_cnt", 32'(edge_cnt), 0);
        check("gl_cnt_clr_width", 32'(cnt_clr), 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset in DATA at bit 4, then a clean frame
        send_bits(frame(8'h99, 1'b0, 1'b0, 1'b1), 4);
        check("mid_busy",    32'(busy),    1);
        check("mid_bit_cnt", 32'(bit_cnt), 4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy",    32'(busy),       0);
        check("mid_rst_en_cnt",  32'(en_counter), 0);
        check("mid_rst_cnt_clr", 32'(cnt_clr),    0);
        check("mid_rst_dv",      32'(data_valid), 0);
        check("mid_rst_p_data",  32'(p_data),     0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_expect(1'b1, 1'b0, 1'b0, 8'h6B);
        send_bits(frame(8'h6B, 1'b0, 1'b0, 1'b1), 10);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back frames, second start during the cnt_clr cycle
        sb_expect(1'b1, 1'b0, 1'b0, 8'h12);
        sb_expect(1'b1, 1'b0, 1'b0, 8'h34);
        send_bits(frame(8'h12, 1'b0, 1'b0, 1'b1), 10);
        check("b2b_cnt_clr", 32'(cnt_clr), 1);
        send_bits(frame(8'h34, 1'b0, 1'b0, 1'b1), 10);
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
